// File: rtl/control_unit_mc_pkg.sv
// Shared decode constants, control bundle type and FSM/class enums for the
// multi-cycle RV32IM decode stage.
package cu_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_JALR  = 5'b10001;
    localparam logic [4:0] ALU_LUI   = 5'b11000;

    localparam logic [2:0] IMM_U = 3'b000;
    localparam logic [2:0] IMM_J = 3'b001;
    localparam logic [2:0] IMM_I = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_S = 3'b100;

    localparam logic [1:0] WB_PC  = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_ALU = 2'b10;

    typedef struct packed {
        logic [4:0] alu_sel;
        logic       reg_write;
        logic [2:0] mem_write;
        logic [3:0] mem_read;
        logic [3:0] branch_ctrl;
        logic [2:0] imm_sel;
        logic       op1_sel;
        logic       op2_sel;
        logic [1:0] wb_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        alu_sel:     ALU_ADD,
        reg_write:   1'b0,
        mem_write:   3'b000,
        mem_read:    4'b0000,
        branch_ctrl: 4'b0000,
        imm_sel:     IMM_U,
        op1_sel:     1'b0,
        op2_sel:     1'b0,
        wb_sel:      WB_ALU
    };

    typedef enum logic [1:0] {CLS_SINGLE, CLS_MUL, CLS_DIV} op_class_e;
    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

endpackage

// File: rtl/control_unit_mc_if.sv
// IF/ID-side inputs and ID/EX control outputs of the decode stage.
interface control_unit_mc_if;
    logic [31:0] INSTRUCTION;
    logic        VALID_IN;
    logic        STALL_IN;
    logic        FLUSH;
    logic [4:0]  ALU_SELECT;
    logic        REG_WRITE_EN;
    logic [2:0]  MEM_WRITE;
    logic [3:0]  MEM_READ;
    logic [3:0]  BRANCH_CTRL;
    logic [2:0]  IMM_SELECT;
    logic        OP1_SEL;
    logic        OP2_SEL;
    logic [1:0]  WB_VALUE_SELECT;
    logic        VALID_OUT;
    logic        MDU_START;
    logic        STALL_OUT;
    logic        ILLEGAL_INSTR;

    modport master (
        output INSTRUCTION, VALID_IN, STALL_IN, FLUSH,
        input  ALU_SELECT, REG_WRITE_EN, MEM_WRITE, MEM_READ, BRANCH_CTRL,
               IMM_SELECT, OP1_SEL, OP2_SEL, WB_VALUE_SELECT, VALID_OUT,
               MDU_START, STALL_OUT, ILLEGAL_INSTR
    );

    modport slave (
        input  INSTRUCTION, VALID_IN, STALL_IN, FLUSH,
        output ALU_SELECT, REG_WRITE_EN, MEM_WRITE, MEM_READ, BRANCH_CTRL,
               IMM_SELECT, OP1_SEL, OP2_SEL, WB_VALUE_SELECT, VALID_OUT,
               MDU_START, STALL_OUT, ILLEGAL_INSTR
    );
endinterface

// File: rtl/control_unit_mc_decoder.sv
// Combinational RV32IM decoder: control bundle, latency class and illegal flag.
// Illegal-encoding detection is built only when CU_ILLEGAL_DETECT_EN is defined.
module control_decoder
    import cu_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output op_class_e   class_o,
    output logic        illegal_o
);
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       muldiv;
    logic       alt_op;
    logic       unused_fields;

    assign opcode        = instr_i[6:0];
    assign funct3        = instr_i[14:12];
    assign funct7        = instr_i[31:25];
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};
    assign muldiv        = (opcode == OP_REG) && (funct7 == F7_MULDIV);
    // Only SUB, SRA and SRAI carry the alternate-function bit
    assign alt_op = (funct7 == F7_ALT) &&
                    (((opcode == OP_IMM) && (funct3 == 3'b101)) ||
                     ((opcode == OP_REG) && ((funct3 == 3'b000) || (funct3 == 3'b101))));

    always_comb begin
        ctrl_o           = CTRL_BUBBLE;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_sel   = {alt_op, 1'b0, funct3};
        class_o          = CLS_SINGLE;
        illegal_o        = 1'b0;
        case (opcode)
            OP_LUI: begin
                ctrl_o.alu_sel = ALU_LUI;
                ctrl_o.op2_sel = 1'b1;
            end
            OP_AUIPC: begin
                ctrl_o.alu_sel = ALU_ADD;
                ctrl_o.op1_sel = 1'b1;
                ctrl_o.op2_sel = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.alu_sel     = ALU_ADD;
                ctrl_o.imm_sel     = IMM_J;
                ctrl_o.op1_sel     = 1'b1;
                ctrl_o.op2_sel     = 1'b1;
                ctrl_o.wb_sel      = WB_PC;
                ctrl_o.branch_ctrl = 4'b1010;
            end
            OP_JALR: begin
                ctrl_o.alu_sel     = ALU_JALR;
                ctrl_o.imm_sel     = IMM_I;
                ctrl_o.op2_sel     = 1'b1;
                ctrl_o.wb_sel      = WB_PC;
                ctrl_o.branch_ctrl = 4'b1010;
            end
            OP_BRANCH: begin
                ctrl_o.alu_sel     = ALU_ADD;
                ctrl_o.imm_sel     = IMM_B;
                ctrl_o.reg_write   = 1'b0;
                ctrl_o.branch_ctrl = {1'b1, funct3};
            end
            OP_LOAD: begin
                ctrl_o.alu_sel  = ALU_ADD;
                ctrl_o.imm_sel  = IMM_I;
                ctrl_o.op2_sel  = 1'b1;
                ctrl_o.wb_sel   = WB_MEM;
                ctrl_o.mem_read = {1'b1, funct3};
            end
            OP_STORE: begin
                ctrl_o.alu_sel   = ALU_ADD;
                ctrl_o.imm_sel   = IMM_S;
                ctrl_o.op2_sel   = 1'b1;
                ctrl_o.reg_write = 1'b0;
                ctrl_o.mem_write = {1'b1, funct3[1:0]};
            end
            OP_IMM: begin
                ctrl_o.imm_sel = IMM_I;
                ctrl_o.op2_sel = 1'b1;
            end
            OP_REG: begin
                ctrl_o.alu_sel[3] = muldiv;
                if (muldiv) begin
                    class_o = funct3[2] ? CLS_DIV : CLS_MUL;
                end
`ifdef CU_ILLEGAL_DETECT_EN
                illegal_o = !((funct7 == F7_BASE) || muldiv || alt_op);
`endif
            end
            default: begin
`ifdef CU_ILLEGAL_DETECT_EN
                illegal_o = 1'b1;
`endif
            end
        endcase
`ifdef CU_ILLEGAL_DETECT_EN
        if (illegal_o) begin
            ctrl_o  = CTRL_BUBBLE;
            class_o = CLS_SINGLE;
        end
`endif
    end

endmodule

// File: rtl/control_unit_mc.sv
// RV32IM decode stage with registered ID/EX control and a sequencer that holds
// MUL/DIV ops for MUL_CYCLES/DIV_CYCLES. ILLEGAL_INSTR is live with CU_ILLEGAL_DETECT_EN.
module control_unit_mc
    import cu_pkg::*;
#(
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 32
) (
    input logic              CLK,
    input logic              RESET,
    control_unit_mc_if.slave bus
);
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    ctrl_t      dec_ctrl;
    op_class_e  dec_class;
    logic       dec_illegal;
    logic [CNT_W-1:0] load_cnt;
    logic       accept;

    state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       valid_q, valid_d;
    logic       start_q, start_d;
    logic       illegal_q, illegal_d;

    control_decoder u_decoder (
        .instr_i   (bus.INSTRUCTION),
        .ctrl_o    (dec_ctrl),
        .class_o   (dec_class),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        case (dec_class)
            CLS_MUL: load_cnt = MUL_LOAD;
            CLS_DIV: load_cnt = DIV_LOAD;
            default: load_cnt = '0;
        endcase
    end

    // A BUSY slot whose count has run out is as ready as IDLE
    assign accept = ((state_q == ST_IDLE) || (cnt_q == '0)) && !bus.STALL_IN && !bus.FLUSH;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        start_d   = start_q;
        illegal_d = illegal_q;
        if (bus.FLUSH) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            ctrl_d    = CTRL_BUBBLE;
            valid_d   = 1'b0;
            start_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (bus.STALL_IN) begin
            // Everything frozen; a pending start pulse reappears once released
        end else if (accept) begin
            ctrl_d    = bus.VALID_IN ? dec_ctrl : CTRL_BUBBLE;
            illegal_d = bus.VALID_IN && dec_illegal;
            if (bus.VALID_IN && (load_cnt != '0)) begin
                state_d = ST_BUSY;
                cnt_d   = load_cnt;
                valid_d = 1'b0;
                start_d = 1'b1;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                valid_d = bus.VALID_IN;
                start_d = 1'b0;
            end
        end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            valid_d = (cnt_q == CNT_W'(1));
            start_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ctrl_q    <= CTRL_BUBBLE;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.ALU_SELECT      = ctrl_q.alu_sel;
    assign bus.REG_WRITE_EN    = ctrl_q.reg_write;
    assign bus.MEM_WRITE       = ctrl_q.mem_write;
    assign bus.MEM_READ        = ctrl_q.mem_read;
    assign bus.BRANCH_CTRL     = ctrl_q.branch_ctrl;
    assign bus.IMM_SELECT      = ctrl_q.imm_sel;
    assign bus.OP1_SEL         = ctrl_q.op1_sel;
    assign bus.OP2_SEL         = ctrl_q.op2_sel;
    assign bus.WB_VALUE_SELECT = ctrl_q.wb_sel;
    assign bus.VALID_OUT       = valid_q;
    assign bus.MDU_START       = start_q && !bus.STALL_IN;
    assign bus.STALL_OUT       = bus.STALL_IN || ((state_q == ST_BUSY) && (cnt_q != '0));
    assign bus.ILLEGAL_INSTR   = illegal_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// Bench for control_unit_mc (MUL_CYCLES=2, DIV_CYCLES=4): directed literal checks
// plus randomized traffic compared every cycle against an occupancy-based model.
module tb_control_unit_mc;
    localparam int TB_MUL = 2;
    localparam int TB_DIV = 4;
    localparam logic [31:0] I_ADD = 32'h003100B3;
    localparam logic [31:0] I_DIV = 32'h023140B3;

    typedef struct packed {
        logic [4:0] alu;
        logic       rw;
        logic [2:0] mw;
        logic [3:0] mr;
        logic [3:0] br;
        logic [2:0] imm;
        logic       o1;
        logic       o2;
        logic [1:0] wb;
        logic       ill;
        logic       imm_dc;
    } exp_t;

    localparam exp_t BUBBLE = '{alu: 5'd0, rw: 1'b0, mw: 3'd0, mr: 4'd0, br: 4'd0,
                                imm: 3'd0, o1: 1'b0, o2: 1'b0, wb: 2'b10,
                                ill: 1'b0, imm_dc: 1'b0};

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic cmp_en = 1'b0;
    int checks = 0;
    int errors = 0;

    control_unit_mc_if bus_if ();

    control_unit_mc #(.MUL_CYCLES(TB_MUL), .DIV_CYCLES(TB_DIV)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic exp_t exp_decode(input logic [31:0] i);
        exp_t e;
        logic legal;
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        e = BUBBLE;
        e.rw = 1'b1;
        e.alu = {2'b00, f3};
        legal = 1'b1;
        case (op)
            7'h37: begin e.alu = 5'b11000; e.o2 = 1'b1; end
            7'h17: begin e.alu = 5'd0; e.o1 = 1'b1; e.o2 = 1'b1; end
            7'h6F: begin e.alu = 5'd0; e.imm = 3'd1; e.o1 = 1'b1; e.o2 = 1'b1; e.wb = 2'b00; e.br = 4'b1010; end
            7'h67: begin e.alu = 5'b10001; e.imm = 3'd2; e.o2 = 1'b1; e.wb = 2'b00; e.br = 4'b1010; end
            7'h63: begin e.alu = 5'd0; e.imm = 3'd3; e.rw = 1'b0; e.br = {1'b1, f3}; end
            7'h03: begin e.alu = 5'd0; e.imm = 3'd2; e.o2 = 1'b1; e.wb = 2'b01; e.mr = {1'b1, f3}; end
            7'h23: begin e.alu = 5'd0; e.imm = 3'd4; e.o2 = 1'b1; e.rw = 1'b0; e.mw = {1'b1, f3[1:0]}; end
            7'h13: begin
                e.imm = 3'd2;
                e.o2 = 1'b1;
                if (f3 == 3'd5 && f7 == 7'h20) e.alu[4] = 1'b1;
            end
            7'h33: begin
                e.imm_dc = 1'b1;
                if (f7 == 7'h01) e.alu[3] = 1'b1;
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.alu[4] = 1'b1;
                else if (f7 != 7'h00) legal = 1'b0;
            end
            default: begin e.imm_dc = 1'b1; legal = 1'b0; end
        endcase
`ifdef CU_ILLEGAL_DETECT_EN
        if (!legal) begin e = BUBBLE; e.ill = 1'b1; end
`else
        if (!legal) e.imm_dc = 1'b1;
`endif
        return e;
    endfunction

    function automatic int exp_cycles(input logic [31:0] i);
        if (i[6:0] == 7'h33 && i[31:25] == 7'h01) return i[14] ? TB_DIV : TB_MUL;
        return 1;
    endfunction

    // Model: the slot holds one instruction for m_n unstalled cycles (m_age counts them)
    exp_t m_cur = BUBBLE;
    int   m_n = 1;
    int   m_age = 0;
    logic m_vld = 1'b0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET || bus_if.FLUSH) begin
            m_cur <= BUBBLE; m_n <= 1; m_age <= 0; m_vld <= 1'b0;
        end else if (bus_if.STALL_IN) begin
            m_age <= m_age;
        end else if (m_age >= m_n - 1) begin
            m_age <= 0;
            if (bus_if.VALID_IN) begin
                m_cur <= exp_decode(bus_if.INSTRUCTION);
                m_n   <= exp_cycles(bus_if.INSTRUCTION);
                m_vld <= 1'b1;
            end else begin
                m_cur <= BUBBLE; m_n <= 1; m_vld <= 1'b0;
            end
        end else begin
            m_age <= m_age + 1;
        end
    end

    logic [23:0] got_b, exp_b;
    always @(negedge CLK) begin
        if (cmp_en) begin
            got_b = {bus_if.ALU_SELECT, bus_if.REG_WRITE_EN, bus_if.MEM_WRITE, bus_if.MEM_READ,
                     bus_if.BRANCH_CTRL, bus_if.IMM_SELECT, bus_if.OP1_SEL, bus_if.OP2_SEL,
                     bus_if.WB_VALUE_SELECT};
            exp_b = {m_cur.alu, m_cur.rw, m_cur.mw, m_cur.mr, m_cur.br, m_cur.imm,
                     m_cur.o1, m_cur.o2, m_cur.wb};
            if (m_cur.imm_dc) begin got_b[6:4] = 3'd0; exp_b[6:4] = 3'd0; end
            check("model_bundle", 32'(got_b), 32'(exp_b));
            check("model_valid", 32'(bus_if.VALID_OUT), 32'(m_vld && (m_age == m_n - 1)));
            check("model_mdu_start", 32'(bus_if.MDU_START), 32'((m_n > 1) && (m_age == 0) && !bus_if.STALL_IN));
            check("model_stall_out", 32'(bus_if.STALL_OUT), 32'(bus_if.STALL_IN || (m_age < m_n - 1)));
            check("model_illegal", 32'(bus_if.ILLEGAL_INSTR), 32'(m_cur.ill));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic fl);
        bus_if.VALID_IN = v;
        bus_if.INSTRUCTION = ins;
        bus_if.STALL_IN = st;
        bus_if.FLUSH = fl;
    endtask

    logic [6:0] opc_tab [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                                 7'h33, 7'h33, 7'h33, 7'h33};

    initial begin
        logic [31:0] ins;
        int k;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        #2 RESET = 1'b1;
        #1 cmp_en = 1'b1;
        check("reset_valid", 32'(bus_if.VALID_OUT), 32'd0);
        check("reset_wb", 32'(bus_if.WB_VALUE_SELECT), 32'd2);
        check("reset_stall_out", 32'(bus_if.STALL_OUT), 32'd0);
        tick();
        RESET = 1'b0;

        // ADD x1,x2,x3
        drive(1'b1, I_ADD, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        #1;
        check("add_alu", 32'(bus_if.ALU_SELECT), 32'd0);
        check("add_regwrite", 32'(bus_if.REG_WRITE_EN), 32'd1);
        check("add_wb", 32'(bus_if.WB_VALUE_SELECT), 32'd2);
        check("add_op2", 32'(bus_if.OP2_SEL), 32'd0);
        check("add_valid", 32'(bus_if.VALID_OUT), 32'd1);
        check("add_stall_out", 32'(bus_if.STALL_OUT), 32'd0);

        // DIV occupies cycles 1-4; ADD queued behind it
        drive(1'b1, I_DIV, 1'b0, 1'b0);
        tick();
        drive(1'b1, I_ADD, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            #1;
            check("div_alu", 32'(bus_if.ALU_SELECT), 32'b01100);
            check("div_mdu_start", 32'(bus_if.MDU_START), 32'(c == 1));
            check("div_stall_out", 32'(bus_if.STALL_OUT), 32'(c <= 3));
            check("div_valid", 32'(bus_if.VALID_OUT), 32'(c == 4));
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        #1;
        check("after_div_valid", 32'(bus_if.VALID_OUT), 32'd1);
        check("after_div_alu", 32'(bus_if.ALU_SELECT), 32'd0);
        tick();

        // DIV stalled for 3 cycles at cnt=2
        drive(1'b1, I_DIV, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_alu", 32'(bus_if.ALU_SELECT), 32'b01100);
            check("stall_valid", 32'(bus_if.VALID_OUT), 32'd0);
            check("stall_stall_out", 32'(bus_if.STALL_OUT), 32'd1);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            #1;
            check("release_valid", 32'(bus_if.VALID_OUT), 32'(c == 3));
            tick();
        end

        // FLUSH while BUSY and stalled
        drive(1'b1, I_DIV, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        tick();
        #1;
        check("flush_valid", 32'(bus_if.VALID_OUT), 32'd0);
        check("flush_alu", 32'(bus_if.ALU_SELECT), 32'd0);
        check("flush_stall_out_hi", 32'(bus_if.STALL_OUT), 32'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        #1;
        check("flush_stall_out_lo", 32'(bus_if.STALL_OUT), 32'd0);
        tick();

        // Unknown opcode 0x7F
        drive(1'b1, 32'h0000007F, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        #1;
        check("ill_valid", 32'(bus_if.VALID_OUT), 32'd1);
`ifdef CU_ILLEGAL_DETECT_EN
        check("ill_flag", 32'(bus_if.ILLEGAL_INSTR), 32'd1);
        check("ill_regwrite", 32'(bus_if.REG_WRITE_EN), 32'd0);
        check("ill_store", 32'(bus_if.MEM_WRITE[2]), 32'd0);
`else
        check("ill_flag", 32'(bus_if.ILLEGAL_INSTR), 32'd0);
        check("ill_regwrite", 32'(bus_if.REG_WRITE_EN), 32'd1);
`endif
        tick();

        // RESET mid-DIV at cnt=2
        drive(1'b1, I_DIV, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        RESET = 1'b1;
        #1;
        check("rst_mid_valid", 32'(bus_if.VALID_OUT), 32'd0);
        check("rst_mid_alu", 32'(bus_if.ALU_SELECT), 32'd0);
        check("rst_mid_wb", 32'(bus_if.WB_VALUE_SELECT), 32'd2);
        check("rst_mid_stall_hi", 32'(bus_if.STALL_OUT), 32'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        #1;
        check("rst_mid_stall_lo", 32'(bus_if.STALL_OUT), 32'd0);
        tick();
        RESET = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            ins = $urandom;
            k = $urandom_range(0, 9);
            if (k < 8) ins[6:0] = opc_tab[$urandom_range(0, 11)];
            k = $urandom_range(0, 3);
            if (k == 0) ins[31:25] = 7'h00;
            else if (k == 1) ins[31:25] = 7'h20;
            else if (k == 2) ins[31:25] = 7'h01;
            drive($urandom_range(0, 4) != 0, ins, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 19) == 0);
            RESET = ($urandom_range(0, 199) == 0);
            tick();
        end
        RESET = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
